// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the memory-mapped UART.
//   - Word addresses of the TXD, RXD and CON registers.
//   - Bit positions inside the CON register.
//   - State encoding shared by the TX and RX frame sequencers.
//   - Tick reload values for a full bit and for half a bit (start-bit midpoint).
package uart_pkg;

    localparam logic [31:0] UART_TXD_ADDR = 32'h4000_0018;
    localparam logic [31:0] UART_RXD_ADDR = 32'h4000_001C;
    localparam logic [31:0] UART_CON_ADDR = 32'h4000_0020;

    localparam int CON_IRQ_EN   = 1;
    localparam int CON_TX_DONE  = 2;
    localparam int CON_RX_VALID = 3;
    localparam int CON_TX_BUSY  = 4;
    localparam int CON_OVERRUN  = 5;

    // Ticks are counted down and the terminal count is 0, so a full bit
    // reloads 15 (16 ticks) and the start-bit midpoint reloads 7 (8 ticks).
    localparam logic [3:0] TICKS_BIT_M1  = 4'd15;
    localparam logic [3:0] TICKS_HALF_M1 = 4'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running 16x oversample tick generator.
//   clk   in  system clock
//   reset in  asynchronous, active-high reset
//   tick  out one-cycle pulse every DIV clocks
// The counter runs down and reloads at its terminal count of 0; it resets to
// 0, so the first tick is issued in the first cycle after reset.
module uart_baud_tick #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] RELOAD = W'(DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (cnt == '0) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped UART responder on the single-cycle MIPS data bus.
//   clk        in  system clock
//   reset      in  asynchronous, active-high reset
//   Address    in  CPU byte address
//   WriteData  in  store data
//   MemRead    in  load strobe (read side effects commit at the clock edge)
//   MemWrite   in  store strobe
//   ReadData   out load data, combinational from Address and registers
//   rx         in  serial input, idle high, asynchronous to clk
//   tx         out serial output, idle high
//   irq        out interrupt, only when UART_IRQ_EN is defined
// Build option: define UART_IRQ_EN to add the irq port and the writable
// CON.irq_en bit; without it CON bit1 reads 0 and CON stores are ignored.
//
// TX and RX sequencers (both use uart_state_t):
//   state | meaning
//   IDLE  | line idle; TX waits for a TXD store, RX waits for a low on rx
//   START | TX drives 0 for 16 ticks; RX waits 8 ticks then checks for low
//   DATA  | 8 bits LSB first, 16 ticks each (RX samples mid-bit)
//   STOP  | TX drives 1 for 16 ticks; RX samples once, high = good byte
module uart_mmio
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] ReadData,
    input  logic        rx,
    output logic        tx
`ifdef UART_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int DIV_RAW = CLK_FREQ / (BAUD * 16);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;

    logic tick;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // ---------------------------------------------------------------- decode
    logic is_txd, is_rxd, is_con;
    logic txd_store, rxd_load, con_load;

    assign is_txd    = (Address == UART_TXD_ADDR);
    assign is_rxd    = (Address == UART_RXD_ADDR);
    assign is_con    = (Address == UART_CON_ADDR);
    assign txd_store = MemWrite & is_txd;
    assign rxd_load  = MemRead & is_rxd;
    assign con_load  = MemRead & is_con;

    logic unused_wdata;
    assign unused_wdata = ^WriteData[31:8];

    // -------------------------------------------------------------------- TX
    uart_state_t tx_state, tx_state_nx;
    logic [7:0]  tx_shift, tx_shift_nx;
    logic [3:0]  tx_cnt, tx_cnt_nx;
    logic [2:0]  tx_bit, tx_bit_nx;
    logic        tx_nx;
    logic        tx_done_set;
    logic        tx_busy;

    assign tx_busy = (tx_state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state <= IDLE;
            tx_shift <= '0;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx       <= 1'b1;
        end else begin
            tx_state <= tx_state_nx;
            tx_shift <= tx_shift_nx;
            tx_cnt   <= tx_cnt_nx;
            tx_bit   <= tx_bit_nx;
            tx       <= tx_nx;
        end
    end

    always_comb begin
        tx_state_nx = tx_state;
        tx_shift_nx = tx_shift;
        tx_cnt_nx   = tx_cnt;
        tx_bit_nx   = tx_bit;
        tx_done_set = 1'b0;
        unique case (tx_state)
            IDLE: begin
                if (txd_store) begin
                    tx_state_nx = START;
                    tx_shift_nx = WriteData[7:0];
                    tx_cnt_nx   = TICKS_BIT_M1;
                end
            end
            START: begin
                if (tick) begin
                    if (tx_cnt == 4'd0) begin
                        tx_state_nx = DATA;
                        tx_cnt_nx   = TICKS_BIT_M1;
                        tx_bit_nx   = 3'd0;
                    end else begin
                        tx_cnt_nx = tx_cnt - 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (tx_cnt == 4'd0) begin
                        tx_cnt_nx   = TICKS_BIT_M1;
                        tx_shift_nx = {1'b0, tx_shift[7:1]};
                        if (tx_bit == 3'd7) begin
                            tx_state_nx = STOP;
                        end else begin
                            tx_bit_nx = tx_bit + 3'd1;
                        end
                    end else begin
                        tx_cnt_nx = tx_cnt - 4'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (tx_cnt == 4'd0) begin
                        tx_state_nx = IDLE;
                        tx_done_set = 1'b1;
                    end else begin
                        tx_cnt_nx = tx_cnt - 4'd1;
                    end
                end
            end
            default: tx_state_nx = IDLE;
        endcase

        // tx is registered from the next state so the line never glitches
        // on a multi-bit state change.
        case (tx_state_nx)
            START:   tx_nx = 1'b0;
            DATA:    tx_nx = tx_shift_nx[0];
            default: tx_nx = 1'b1;
        endcase
    end

    // -------------------------------------------------------------------- RX
    logic rx_meta, rx_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    uart_state_t rx_state, rx_state_nx;
    logic [7:0]  rx_shift, rx_shift_nx;
    logic [3:0]  rx_cnt, rx_cnt_nx;
    logic [2:0]  rx_bit, rx_bit_nx;
    logic        rx_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state <= IDLE;
            rx_shift <= '0;
            rx_cnt   <= '0;
            rx_bit   <= '0;
        end else begin
            rx_state <= rx_state_nx;
            rx_shift <= rx_shift_nx;
            rx_cnt   <= rx_cnt_nx;
            rx_bit   <= rx_bit_nx;
        end
    end

    always_comb begin
        rx_state_nx = rx_state;
        rx_shift_nx = rx_shift;
        rx_cnt_nx   = rx_cnt;
        rx_bit_nx   = rx_bit;
        rx_done     = 1'b0;
        unique case (rx_state)
            IDLE: begin
                if (!rx_sync) begin
                    rx_state_nx = START;
                    rx_cnt_nx   = TICKS_HALF_M1;
                end
            end
            START: begin
                if (tick) begin
                    if (rx_cnt == 4'd0) begin
                        // A line that is high again at mid-start was a glitch.
                        if (rx_sync) begin
                            rx_state_nx = IDLE;
                        end else begin
                            rx_state_nx = DATA;
                            rx_cnt_nx   = TICKS_BIT_M1;
                            rx_bit_nx   = 3'd0;
                        end
                    end else begin
                        rx_cnt_nx = rx_cnt - 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (rx_cnt == 4'd0) begin
                        rx_cnt_nx   = TICKS_BIT_M1;
                        rx_shift_nx = {rx_sync, rx_shift[7:1]};
                        if (rx_bit == 3'd7) begin
                            rx_state_nx = STOP;
                        end else begin
                            rx_bit_nx = rx_bit + 3'd1;
                        end
                    end else begin
                        rx_cnt_nx = rx_cnt - 4'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (rx_cnt == 4'd0) begin
                        rx_state_nx = IDLE;
                        rx_done     = rx_sync;
                    end else begin
                        rx_cnt_nx = rx_cnt - 4'd1;
                    end
                end
            end
            default: rx_state_nx = IDLE;
        endcase
    end

    // ----------------------------------------------------------------- flags
    // Set always beats clear when both happen in the same cycle.
    logic [7:0] rx_data;
    logic       rx_valid, overrun, tx_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            if (rx_done) begin
                rx_data <= rx_shift;
            end

            if (rx_done) begin
                rx_valid <= 1'b1;
            end else if (rxd_load) begin
                rx_valid <= 1'b0;
            end

            if (rx_done && rx_valid) begin
                overrun <= 1'b1;
            end else if (con_load) begin
                overrun <= 1'b0;
            end

            if (tx_done_set) begin
                tx_done <= 1'b1;
            end else if (con_load) begin
                tx_done <= 1'b0;
            end
        end
    end

`ifdef UART_IRQ_EN
    logic irq_en;
    logic con_store;

    assign con_store = MemWrite & is_con;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_en <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (con_store) begin
                irq_en <= WriteData[CON_IRQ_EN];
            end
            irq <= irq_en & (rx_valid | tx_done);
        end
    end
`endif

    // -------------------------------------------------------------- readback
    always_comb begin
        ReadData = '0;
        if (is_rxd) begin
            ReadData[7:0] = rx_data;
        end else if (is_con) begin
            ReadData[CON_TX_DONE]  = tx_done;
            ReadData[CON_RX_VALID] = rx_valid;
            ReadData[CON_TX_BUSY]  = tx_busy;
            ReadData[CON_OVERRUN]  = overrun;
`ifdef UART_IRQ_EN
            ReadData[CON_IRQ_EN]   = irq_en;
`endif
        end
    end

endmodule

// File: doc/uart_mmio.md
# uart_mmio

Memory-mapped UART responder for the single-cycle MIPS data bus. It serves the CPU's load/store traffic to the UART window at 0x40000018–0x40000020: transmit-data write, receive-data read, control/status read. It serialises bytes onto `tx`, deserialises bytes from `rx`, and exposes polling status. It sits beside data memory on the CPU's load/store path and answers combinationally, as data memory does.

## Interface
Parameters:
- `CLK_FREQ`, default 100_000_000: system clock in Hz.
- `BAUD`, default 9600: line rate. `DIV = CLK_FREQ/(BAUD*16)` (integer division, must be ≥1) sets the 16x oversample tick.

Ports (one clock; `reset` is asynchronous, active-high):
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `Address`  in  32  CPU byte address.
- `WriteData`  in  32  store data.
- `MemRead`  in  1  load strobe.
- `MemWrite`  in  1  store strobe.
- `ReadData`  out  32  load data, combinational.
- `rx`  in  1  serial input, idle high, asynchronous.
- `tx`  out  1  serial output, idle high.
- `irq`  out  1  present only with `UART_IRQ_EN`.

## Operation
Register map (word addresses; other addresses read 0, writes ignored):
- 0x40000018 TXD (W): a store with `MemWrite=1` captures `WriteData[7:0]` at the clock edge and starts a frame if the transmitter is idle. A store while busy is dropped.
- 0x4000001C RXD (R): `{24'b0, rx_data}`. A load with `MemRead=1` clears `rx_valid` at the clock edge.
- 0x40000020 CON (R): bit2 `tx_done` (sticky), bit3 `rx_valid`, bit4 `tx_busy`, bit5 `overrun` (sticky), bit1 `irq_en` (IRQ build only, writable). All other bits are 0. A load clears `tx_done` and `overrun` at the clock edge.

TX FSM: IDLE → START → DATA → STOP → IDLE.
- START: drives 0.
- DATA: 8 bits, LSB first.
- STOP: drives 1.
- Each state lasts 16 ticks. `tx_done` is set on the STOP→IDLE transition.

RX FSM: IDLE → START → DATA → STOP → IDLE.
- `rx` passes through a 2-flop synchroniser.
- IDLE → START on a synchronised low.
- START samples at tick 8. If the line is high, the start is false and the FSM returns to IDLE.
- DATA samples every 16 ticks, LSB first.
- STOP samples once. If high, `rx_data` is loaded and `rx_valid` is set. If low (framing error), the byte is discarded and flags are unchanged.

Boundary conditions:
- Byte completes while `rx_valid=1`: `rx_data` is overwritten and `overrun` is set.
- Byte completes in the same cycle as an RXD load: the new byte wins, so `rx_valid` stays 1.
- CON load coincides with `tx_done` set: the flag stays set.
- TXD store coincides with STOP→IDLE: the store is dropped, because `tx_busy` is still 1 that cycle.

## Timing
- Reset values: `tx=1`, `ReadData` depends only on the decode (CON reads 0, RXD reads 0), both FSMs IDLE, all flags and `rx_data` 0, tick counter 0, `irq=0`.
- `ReadData` has zero latency (combinational from `Address` and registers). Side effects commit at the clock edge.
- `tx_busy` reads 1 from the cycle after the TXD store edge. `tx` falls in that same cycle.
- Frame length: 160 ticks = 160·DIV cycles. `tx_busy` deasserts after the full stop bit.
- `rx_valid` is set at most DIV·16+2 cycles after the stop-bit midpoint on the line.
- Reset mid-frame: `tx` goes high immediately (asynchronous) and the partial frame is lost.

## Configuration
- `UART_IRQ_EN` defined: adds `irq` port and writable CON bit1 `irq_en` (stores to 0x40000020 write bit1). `irq = irq_en & (rx_valid | tx_done)`, registered, 1-cycle lag.
- `UART_IRQ_EN` undefined: no `irq` port, CON bit1 reads 0, CON stores ignored.

## Structure
- Package `uart_pkg`:
  - address constants `UART_TXD_ADDR`, `UART_RXD_ADDR`, `UART_CON_ADDR`
  - CON bit indices
  - enum `uart_state_t {IDLE, START, DATA, STOP}`, shared by TX and RX
- Sub-module `uart_baud_tick`: free-running DIV counter, one-cycle `tick` pulse, shared by TX and RX.
- Decode, registers and both FSMs live in `uart_mmio`.

## Test plan
Bench uses CLK_FREQ=1_600_000 and BAUD=10_000, so DIV=10 and one bit = 160 cycles.
1. Reset with no traffic → `tx=1`; CON load reads 0x00000000; RXD load reads 0x00000000.
2. Store 0x41 to 0x40000018 → `tx` pattern 0,1,0,0,0,0,0,1,0,1 at 160 cycles per bit; CON=0x10 during the frame; CON=0x04 afterwards; CON=0x00 on the next load.
3. Drive serial 0x5A on `rx` → CON=0x08; RXD=0x5A; CON=0x00 after the RXD load.
4. `rx` low pulse of 40 cycles → no `rx_valid`; CON stays 0x00.
5. Send 0x11 then 0x22 with no RXD load → RXD=0x22; CON=0x28; CON=0x08 on the following load.
6. Assert `reset` at bit 4 of a TX frame → `tx=1` in the same cycle; CON=0x00. A subsequent store of 0x33 transmits a correct full frame.
